// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: duty range, command layout, FSM states.
package pwm_ramp_ctrl_pkg;

    localparam int unsigned FRAME_CLKS_DEFAULT = 240000;
    localparam int unsigned DC_W               = 7;
    localparam int unsigned STEP_W             = 4;
    localparam int unsigned HOLD_W             = 8;
    localparam int unsigned CMD_W              = DC_W + STEP_W + HOLD_W;

    localparam logic [DC_W-1:0] DC_MAX_DEFAULT  = 7'd100;
    localparam logic [DC_W-1:0] DC_INIT_DEFAULT = 7'd50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } ramp_state_e;

    typedef struct packed {
        logic [DC_W-1:0]   target;
        logic [STEP_W-1:0] step;
        logic [HOLD_W-1:0] hold;
    } ramp_cmd_t;

    function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] v,
                                                 input logic [DC_W-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/pwm_cmd_fifo.sv
// Two-entry synchronous command FIFO with flush; also reports next-cycle emptiness.
module pwm_cmd_fifo
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push_s, pop_s;

    assign full      = (cnt_q == 2'd2);
    assign empty     = (cnt_q == 2'd0);
    assign empty_nxt = (cnt_d == 2'd0);
    assign pop_data  = mem_q[rd_q];
    assign push_s    = push && !full;
    assign pop_s     = pop && !empty;

    // Pointer/count update; flush wins over any push or pop in the same cycle.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_s) begin
                mem_d[wr_q] = push_data;
                wr_d        = ~wr_q;
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = ~rd_q;
            end else begin
                rd_d = rd_q;
            end
            cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Servo position sequencer: queues {target, step, hold} commands and slews the pwm_gen
// duty code by at most one step per frame, updating one cycle before the duty latch.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int unsigned     FRAME_CLKS = FRAME_CLKS_DEFAULT,
    parameter logic [DC_W-1:0] DC_MAX     = DC_MAX_DEFAULT,
    parameter logic [DC_W-1:0] DC_INIT    = DC_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DC_W-1:0]   cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [DC_W-1:0]   dc_out,
    output logic              frame_tick,
    output logic              busy,
    output logic              at_target
);

    localparam int unsigned    CNT_W    = $clog2(FRAME_CLKS);
    localparam logic [CNT_W-1:0] UPD_CNT  = CNT_W'(FRAME_CLKS - 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CLKS - 1);

    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    ramp_state_e       state_q, state_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [DC_W-1:0]   tgt_q, tgt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              frame_tick_q, frame_tick_d;
    logic              busy_q, busy_d;
    logic              at_target_q, at_target_d;

    logic              upd_s;
    logic              push_s, pop_s;
    logic              full_s, empty_s, empty_nxt_s;
    logic [CMD_W-1:0]  push_cmd_s;
    ramp_cmd_t         head_s;
    logic signed [7:0] diff_s;
    logic [7:0]        mag_s;

    assign cmd_ready  = !full_s && !abort;
    assign push_s     = cmd_valid && cmd_ready;
    assign pop_s      = (state_q == ST_LOAD) && !abort;
    assign push_cmd_s = {clamp_dc(cmd_target, DC_MAX), cmd_step, cmd_hold};

    assign dc_out     = dc_q;
    assign frame_tick = frame_tick_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;

    pwm_cmd_fifo #(.WIDTH(CMD_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .empty_nxt (empty_nxt_s)
    );

    // Signed distance to target; magnitude fits 8 bits since both operands are 0..127.
    assign diff_s = $signed({1'b0, tgt_q}) - $signed({1'b0, dc_q});
    assign mag_s  = diff_s[7] ? 8'(-diff_s) : 8'(diff_s);

    // Frame timer, FSM next state, ramp arithmetic and status next values.
    always_comb begin
        frame_cnt_d = (frame_cnt_q == LAST_CNT) ? '0 : frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        upd_s       = (frame_cnt_q == UPD_CNT);
        state_d     = state_q;
        dc_d        = dc_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        hold_cnt_d  = hold_cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
            tgt_d   = dc_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    tgt_d      = head_s.target;
                    step_d     = head_s.step;
                    hold_cnt_d = head_s.hold;
                    state_d    = ST_RAMP;
                end
                ST_RAMP: begin
                    if (upd_s) begin
                        if ((step_q == 4'd0) || (mag_s <= {4'd0, step_q})) begin
                            dc_d    = tgt_q;
                            state_d = ST_HOLD;
                        end else if (diff_s[7]) begin
                            dc_d = dc_q - {3'd0, step_q};
                        end else begin
                            dc_d = dc_q + {3'd0, step_q};
                        end
                    end else begin
                        dc_d = dc_q;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_d = empty_s ? ST_IDLE : ST_LOAD;
                    end else if (upd_s) begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        frame_tick_d = upd_s;
        busy_d       = (state_d != ST_IDLE) || !empty_nxt_s;
        at_target_d  = ((state_d == ST_HOLD) || (state_d == ST_IDLE)) && (dc_d == tgt_d);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            state_q      <= ST_IDLE;
            dc_q         <= DC_INIT;
            tgt_q        <= DC_INIT;
            step_q       <= 4'd0;
            hold_cnt_q   <= 8'd0;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b1;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            state_q      <= state_d;
            dc_q         <= dc_d;
            tgt_q        <= tgt_d;
            step_q       <= step_d;
            hold_cnt_q   <= hold_cnt_d;
            frame_tick_q <= frame_tick_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench: expected duty codes are queued with each command and popped by a
// monitor on every dc_out change; directed checks cover reset, queue-full and abort.
module tb_pwm_ramp_ctrl;

    localparam int unsigned FC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_target = 7'd0;
    logic [3:0] cmd_step = 4'd0;
    logic [7:0] cmd_hold = 8'd0;
    logic       abort = 1'b0;
    logic [6:0] dc_out;
    logic       frame_tick;
    logic       busy;
    logic       at_target;

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    logic [6:0] exp_q [$];
    logic [6:0] prev_dc;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.FRAME_CLKS(FC), .DC_MAX(7'd100), .DC_INIT(7'd50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .dc_out     (dc_out),
        .frame_tick (frame_tick),
        .busy       (busy),
        .at_target  (at_target)
    );

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: every duty change must match the next expected value and land in the latch cycle.
    initial begin
        prev_dc = 7'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (dc_out !== prev_dc)) begin
                if (exp_q.size() == 0) begin
                    chk("dc_unexpected_change", int'(dc_out), int'(prev_dc));
                end else begin
                    chk("dc_step", int'(dc_out), int'(exp_q.pop_front()));
                    chk("dc_align_tick", int'(frame_tick), 1);
                end
            end
            prev_dc = dc_out;
        end
    end

    task automatic send(input logic [6:0] t, input logic [3:0] s, input logic [7:0] h);
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        cmd_hold   = h;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_dc(input logic [6:0] v, input int budget);
        int n;
        n = 0;
        while (dc_out !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_dc", int'(dc_out), int'(v));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        // Reset with a command offered: nothing may be queued.
        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = 7'd20;
        cmd_step   = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dc", int'(dc_out), 50);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_tick", int'(frame_tick), 0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_push_busy", int'(busy), 0);
        chk("no_push_dc", int'(dc_out), 50);

        // Ramp up 50 -> 60 by 4, hold 2 frames.
        exp_q.push_back(7'd54);
        exp_q.push_back(7'd58);
        exp_q.push_back(7'd60);
        send(7'd60, 4'd4, 8'd2);
        wait_dc(7'd60, 100);
        chk("ramp_at_target", int'(at_target), 1);
        repeat (16) @(negedge clk);
        chk("hold_busy", int'(busy), 1);
        @(negedge clk);
        chk("hold_done_busy", int'(busy), 0);

        // Clamp-and-jump to 100, then ramp down by 15 to 0.
        exp_q.push_back(7'd100);
        exp_q.push_back(7'd85);
        exp_q.push_back(7'd70);
        exp_q.push_back(7'd55);
        exp_q.push_back(7'd40);
        exp_q.push_back(7'd25);
        exp_q.push_back(7'd10);
        exp_q.push_back(7'd0);
        send(7'd127, 4'd0, 8'd0);
        send(7'd0, 4'd15, 8'd0);
        wait_dc(7'd0, 300);
        chk("down_at_target", int'(at_target), 1);
        wait_idle(50);

        // Queue full: third command waits for the first pop; order preserved.
        exp_q.push_back(7'd10);
        exp_q.push_back(7'd20);
        exp_q.push_back(7'd30);
        exp_q.push_back(7'd25);
        send(7'd20, 4'd10, 8'd1);
        send(7'd30, 4'd0, 8'd0);
        chk("full_ready", int'(cmd_ready), 0);
        send(7'd25, 4'd5, 8'd0);
        wait_dc(7'd25, 400);
        wait_idle(50);

        // Abort in the update cycle while at 58 with a command still queued.
        exp_q.push_back(7'd50);
        exp_q.push_back(7'd54);
        exp_q.push_back(7'd58);
        send(7'd50, 4'd0, 8'd0);
        send(7'd70, 4'd4, 8'd0);
        send(7'd10, 4'd0, 8'd0);
        wait_dc(7'd58, 400);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_ready", int'(cmd_ready), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_dc", int'(dc_out), 58);
        chk("abort_busy", int'(busy), 0);
        chk("abort_at_target", int'(at_target), 1);
        repeat (24) @(negedge clk);
        chk("abort_dc_frozen", int'(dc_out), 58);
        chk("abort_stays_idle", int'(busy), 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
